// File: rtl/chev_pkg.sv
// rtl/chev_pkg.sv - shared state enum, degree default and fixed-point limit for the Chebyshev map iterator
package chev_pkg;

  // Sequencer states of the map iterator
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_EMIT = 2'd2
  } chev_state_e;

  localparam int MAX_DEG_DEFAULT = 4;

  // +1.0 in Q2.(w-2); also the symmetric saturation bound of every stored value
  function automatic longint chev_one(input int w);
    return longint'(1) << (w - 2);
  endfunction

endpackage

// File: rtl/chev_step.sv
// rtl/chev_step.sv - one Chebyshev recurrence step: sat(2*x*tcur - tprev)
module chev_step
  import chev_pkg::*;
#(
  parameter int W = 32
) (
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] tcur,
  input  logic signed [W-1:0] tprev,
  output logic signed [W-1:0] tnext
);

  localparam logic signed [W-1:0]   ONE = W'(chev_one(W));
  localparam logic signed [2*W-1:0] LIM = (2*W)'(chev_one(W));

  logic signed [2*W-1:0] x_e;
  logic signed [2*W-1:0] tcur_e;
  logic signed [2*W-1:0] tprev_e;
  logic signed [2*W-1:0] prod;
  logic signed [2*W-1:0] scaled;
  logic signed [2*W-1:0] diff;

  // Operands widened up front so the product keeps all 2W bits
  assign x_e     = {{W{x[W-1]}}, x};
  assign tcur_e  = {{W{tcur[W-1]}}, tcur};
  assign tprev_e = {{W{tprev[W-1]}}, tprev};

  // Shifting by W-3 instead of W-2 folds in the factor of two; >>> floors toward -inf
  assign prod   = x_e * tcur_e;
  assign scaled = prod >>> (W - 3);
  assign diff   = scaled - tprev_e;

  // Clamp the recurrence result back into [-ONE, +ONE]
  always_comb begin
    tnext = diff[W-1:0];
    if (diff > LIM) begin
      tnext = ONE;
    end else if (diff < -LIM) begin
      tnext = -ONE;
    end
  end

endmodule

// File: rtl/chebyshev_map_iter.sv
// rtl/chebyshev_map_iter.sv - iterates x <- T_k(x) in fixed point with a valid/ready output
module chebyshev_map_iter
  import chev_pkg::*;
#(
  parameter int W       = 32,
  parameter int MAX_DEG = MAX_DEG_DEFAULT,
  parameter int ITER_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [W-1:0]      seed,
  input  logic        [2:0]        degree,
  input  logic        [ITER_W-1:0] n_iter,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic signed [W-1:0]      xtn,
  output logic                     busy,
  output logic                     done
);

  localparam logic signed [W-1:0] ONE   = W'(chev_one(W));
  localparam logic        [2:0]   MAX_K = 3'(MAX_DEG);

  chev_state_e             state;
  logic signed [W-1:0]     x_q;
  logic signed [W-1:0]     tprev;
  logic signed [W-1:0]     tcur;
  logic signed [W-1:0]     tnext;
  logic        [2:0]       j;
  logic        [2:0]       deg_q;
  logic        [ITER_W-1:0] n_q;
  logic        [ITER_W-1:0] cnt;
  logic        [ITER_W-1:0] cnt_inc;

  // Seed may arrive anywhere in the Q2 range; the map is only defined on [-1, 1]
  function automatic logic signed [W-1:0] sat_seed(input logic signed [W-1:0] v);
    if (v > ONE) return ONE;
    if (v < -ONE) return -ONE;
    return v;
  endfunction

  // Degrees below two would make the step loop empty, so they behave as T_2
  function automatic logic [2:0] clamp_deg(input logic [2:0] d);
    if (d < 3'd2) return 3'd2;
    if (d > MAX_K) return MAX_K;
    return d;
  endfunction

  assign cnt_inc = cnt + ITER_W'(1);

  chev_step #(
    .W(W)
  ) u_step (
    .x    (x_q),
    .tcur (tcur),
    .tprev(tprev),
    .tnext(tnext)
  );

  // Sequencer: load, k-1 recurrence steps, then hold the iterate until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      x_q       <= '0;
      tprev     <= '0;
      tcur      <= '0;
      j         <= '0;
      deg_q     <= '0;
      n_q       <= '0;
      cnt       <= '0;
      xtn       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // done is still high on the cycle after completion; a start there is dropped
          if (start && !done) begin
            deg_q <= clamp_deg(degree);
            n_q   <= n_iter;
            cnt   <= '0;
            x_q   <= sat_seed(seed);
            tprev <= ONE;
            tcur  <= sat_seed(seed);
            j     <= 3'd1;
            if (n_iter == '0) begin
              done <= 1'b1;
            end else begin
              state <= ST_STEP;
              busy  <= 1'b1;
            end
          end
        end
        ST_STEP: begin
          tprev <= tcur;
          tcur  <= tnext;
          j     <= j + 3'd1;
          if (j + 3'd1 == deg_q) begin
            xtn       <= tnext;
            out_valid <= 1'b1;
            state     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            cnt       <= cnt_inc;
            out_valid <= 1'b0;
            if (cnt_inc == n_q) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              // The accepted iterate becomes the next map input
              x_q   <= xtn;
              tprev <= ONE;
              tcur  <= xtn;
              j     <= 3'd1;
              state <= ST_STEP;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chebyshev_map_iter.sv
// tb/tb_chebyshev_map_iter.sv - self-checking bench for chebyshev_map_iter
module tb_chebyshev_map_iter;

  localparam longint ONE = longint'(1) << 30;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] seed;
  logic [2:0]  degree;
  logic [15:0] n_iter;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] xtn;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  chebyshev_map_iter dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .seed     (seed),
    .degree   (degree),
    .n_iter   (n_iter),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .xtn      (xtn),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint s;
    int     d;
    int     n;
    longint exp_x;
    int     k;
  } vec_t;

  vec_t   vecs[6];
  longint got[$];
  int     gcyc[$];
  int     done_at;
  int     done_after;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > ONE) return ONE;
    if (v < -ONE) return -ONE;
    return v;
  endfunction

  function automatic int kclamp(input int d);
    if (d < 2) return 2;
    if (d > 4) return 4;
    return d;
  endfunction

  // floor(2*a*b / ONE) computed with ordinary division and an explicit floor fix-up
  function automatic longint fmul2(input longint a, input longint b);
    longint p, q;
    p = 2 * a * b;
    q = p / ONE;
    if (p < 0 && q * ONE != p) q = q - 1;
    return q;
  endfunction

  // Chebyshev polynomial T_k(x) via T_{n+1} = 2x T_n - T_{n-1}, saturating each term
  function automatic longint cheb(input longint x, input int k);
    longint a, b, c;
    a = ONE;
    b = x;
    for (int i = 2; i <= k; i++) begin
      c = sat(fmul2(x, b) - a);
      a = b;
      b = c;
    end
    return b;
  endfunction

  // Starts a run and records every accepted iterate with the cycle it was accepted in
  task automatic run(input longint s, input int d, input int n, input bit rnd);
    got.delete();
    gcyc.delete();
    done_at = -1;
    @(negedge clk);
    seed      = s[31:0];
    degree    = d[2:0];
    n_iter    = n[15:0];
    start     = 1'b1;
    out_ready = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      start  = 1'b0;
      degree = 3'($urandom);
      n_iter = 16'($urandom);
      out_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      if (out_valid && out_ready) begin
        got.push_back(longint'($signed(xtn)));
        gcyc.push_back(c);
      end
      if (done) begin
        done_at = c;
        break;
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    done_after = int'(done);
    if (done_at < 0) check("run_timeout", 0, 1);
  endtask

  initial begin
    int     c;
    int     acc;
    int     seen;
    longint xm;
    longint sv;
    int     k;
    int     n;

    vecs[0] = '{s: 536870912,  d: 2, n: 3, exp_x: -536870912,  k: 2};
    vecs[1] = '{s: 536870912,  d: 3, n: 2, exp_x: -1073741824, k: 3};
    vecs[2] = '{s: 1073741824, d: 4, n: 4, exp_x: 1073741824,  k: 4};
    vecs[3] = '{s: 0,          d: 3, n: 2, exp_x: 0,           k: 3};
    vecs[4] = '{s: 2000000000, d: 0, n: 2, exp_x: 1073741824,  k: 2};
    vecs[5] = '{s: 536870912,  d: 2, n: 0, exp_x: 0,           k: 2};

    rst = 1'b1;
    start = 1'b0;
    seed = '0;
    degree = '0;
    n_iter = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_valid", out_valid, 0);
    check("reset_done", done, 0);
    check("reset_xtn", longint'($signed(xtn)), 0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run(vecs[v].s, vecs[v].d, vecs[v].n, 1'b0);
      check($sformatf("v%0d_count", v), got.size(), vecs[v].n);
      for (int i = 0; i < got.size(); i++) begin
        check($sformatf("v%0d_xtn%0d", v, i), got[i], vecs[v].exp_x);
        if (i == 0) check($sformatf("v%0d_latency", v), gcyc[0], vecs[v].k);
        else check($sformatf("v%0d_period%0d", v, i), gcyc[i] - gcyc[i-1], vecs[v].k);
      end
      if (vecs[v].n == 0) check($sformatf("v%0d_done_cyc", v), done_at, 1);
      else if (gcyc.size() > 0) check($sformatf("v%0d_done_cyc", v), done_at, gcyc[gcyc.size()-1] + 1);
      check($sformatf("v%0d_done_width", v), done_after, 0);
    end

    for (int r = 0; r < 16; r++) begin
      sv = longint'($signed(32'($urandom)));
      k  = $urandom_range(7, 0);
      n  = $urandom_range(4, 1);
      run(sv, k, n, r[0]);
      check($sformatf("r%0d_count", r), got.size(), n);
      xm = sat(sv);
      for (int i = 0; i < n; i++) begin
        xm = cheb(xm, kclamp(k));
        if (i < got.size()) check($sformatf("r%0d_xtn%0d", r, i), got[i], xm);
      end
    end

    @(negedge clk);
    out_ready = 1'b0;
    seed = 32'd536870912;
    degree = 3'd3;
    n_iter = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    while (!out_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("stall_latency", c, 3);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", out_valid, 1);
      check("stall_hold", longint'($signed(xtn)), -ONE);
      if (i == 2) begin
        start = 1'b1;
        seed = '0;
        degree = 3'd2;
        n_iter = 16'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("stall_still_valid", out_valid, 1);
    out_ready = 1'b1;
    acc = 0;
    c = 0;
    while (!done && c < 50) begin
      if (out_valid) begin
        acc++;
        check("stall_xtn", longint'($signed(xtn)), -ONE);
      end
      @(negedge clk);
      c++;
    end
    check("stall_count", acc, 2);
    check("stall_done", done, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_on_done_busy", busy, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid || busy) seen++;
      @(negedge clk);
    end
    check("start_on_done_quiet", seen, 0);

    seed = 32'd536870912;
    degree = 3'd4;
    n_iter = 16'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_reset_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_xtn", longint'($signed(xtn)), 0);
    check("abort_done", done, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid || done) seen++;
    end
    check("abort_quiet", seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chebyshev_map_iter.md
CHEBYSHEV_MAP_ITER -- requirements
Module: chebyshev_map_iter

Interface
REQ-001 SHALL have parameter W, default 32: signed fixed-point width, format Q2.(W-2); ONE = 2^(W-2).
REQ-002 SHALL have parameter MAX_DEG, default 4: highest supported Chebyshev degree, range 2..7.
REQ-003 SHALL have parameter ITER_W, default 16: width of the iteration counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: request a run; sampled only in IDLE.
REQ-007 SHALL have port seed, input, W bits: initial x0, signed Q2.(W-2).
REQ-008 SHALL have port degree, input, 3 bits: Chebyshev degree k, captured at start.
REQ-009 SHALL have port n_iter, input, ITER_W bits: number of map iterations, captured at start.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts xtn.
REQ-011 SHALL have port out_valid, output, 1 bit: xtn holds a new iterate.
REQ-012 SHALL have port xtn, output, W bits: current iterate x(i+1) = T_k(x(i)), signed.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when a run completes.

Function
REQ-015 SHALL run an FSM with states IDLE, STEP and EMIT.
REQ-016 SHALL, on start in IDLE, capture the inputs and set x = sat(seed), tprev = ONE, tcur = x, j = 1; it SHALL then enter STEP, or go to IDLE with a done pulse when n_iter = 0.
REQ-017 SHALL, in each STEP cycle, apply tnext = sat(2*x*tcur - tprev), then tprev <= tcur, tcur <= tnext and j++; when j reaches k it SHALL register xtn <= tnext and enter EMIT.
REQ-018 SHALL clamp the captured degree: values 0 and 1 are treated as 2, and values above MAX_DEG as MAX_DEG.
REQ-019 SHALL form the product as a full 2W-bit signed multiply, arithmetically shifted right by W-3 (which includes the x2), truncating toward negative infinity.
REQ-020 SHALL saturate every recurrence result and the loaded seed to [-ONE, +ONE].
REQ-021 SHALL assert out_valid in EMIT and hold xtn stable until out_valid and out_ready are both high.
REQ-022 SHALL, on handshake, increment the iteration count; if the count equals n_iter it SHALL go to IDLE with done = 1 for one cycle, else it SHALL set x = xtn, tprev = ONE, tcur = xtn, j = 1 and go to STEP.
REQ-023 SHALL assert the first out_valid exactly k cycles after the start edge; with out_ready held high, it SHALL produce one iterate every k cycles.
REQ-024 SHALL ignore start while busy; a start in the same cycle as done SHALL be ignored.
REQ-025 SHALL NOT alter captured degree or n_iter when the degree and n_iter inputs change mid-run.

Reset
REQ-026 SHALL, when rst = 1 at a clock edge, force IDLE and drive out_valid = 0, busy = 0, done = 0 and xtn = 0, clearing the counters and tprev/tcur.
REQ-027 SHALL abort a run on reset mid-run without a done pulse; no out_valid SHALL follow until a new start.

Structure
REQ-028 SHALL take from a shared package chev_pkg the FSM state enum, the MAX_DEG default and the ONE/saturation limit function of W.
REQ-029 SHALL hold the combinational recurrence datapath (multiply, shift, subtract, saturate) in one sub-module, chev_step, parametrised by W.
REQ-030 SHALL be 120-400 lines of RTL in total.

Verification (W=32, ONE=1073741824, out_ready=1 unless stated)
REQ-031 SHALL check: seed=536870912, degree=2, n_iter=3 -> xtn=-536870912 three times; first out_valid 2 cycles after start; done after the third handshake.
REQ-032 SHALL check: seed=536870912, degree=3, n_iter=2 -> xtn=-1073741824 twice, one output every 3 cycles.
REQ-033 SHALL check: seed=1073741824, degree=4, n_iter=4 -> xtn=1073741824 each time; separately, seed=0, degree=3 -> xtn=0.
REQ-034 SHALL check: seed=2000000000, degree=0 -> seed saturated to ONE, degree treated as 2, xtn=1073741824; separately, n_iter=0 -> done one cycle after start with no out_valid.
REQ-035 SHALL check: out_ready low for 5 cycles during EMIT -> out_valid and xtn held constant, no count advance; a start pulsed mid-run is ignored.
REQ-036 SHALL check: rst asserted during STEP of a degree-4 run -> next cycle busy=0, out_valid=0, xtn=0, and no done pulse.
